// File: rtl/jt03_bus_writer.sv
// jt03_bus_writer: queued two-phase (address, then data) register writer for the jt03 / YM2203 host bus.
// Define JT03_BUS_WRITER_BUSY_POLL_EN to replace the fixed FM data wait with busy-flag polling.
module jt03_bus_writer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STROBE_TICKS = 2,
    parameter int ADDR_WAIT    = 17,
    parameter int FM_WAIT      = 83,
    parameter int PSG_WAIT     = 2,
    parameter int POLL_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic [7:0] bus_din,
    output logic       bus_addr,
    output logic       bus_cs_n,
    output logic       bus_wr_n,
    input  logic [7:0] bus_dout,
    output logic       idle,
    output logic       err_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, A_SETUP, A_STROBE, A_WAIT, D_SETUP, D_STROBE, D_WAIT, POLL} state_t;

    // A hold of n ticks loads n-1; a zero-length hold still costs one tick.
    function automatic logic [7:0] ticks(input int n);
        return (n <= 1) ? 8'd0 : 8'(n - 1);
    endfunction

    logic [7:0]    fifo_reg  [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_d;
    logic          full, push, pop, fm;

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d, reg_q, data_q, din_d;
    logic       cs_d, wr_d, addr_d;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && (count != '0);
    assign fm        = (reg_q >= 8'h10);

    always_comb begin
        count_d = count;
        if (push && !pop)
            count_d = count + (AW+1)'(1);
        else if (pop && !push)
            count_d = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= cmd_reg;
            fifo_data[wr_ptr] <= cmd_data;
        end
    end

`ifdef JT03_BUS_WRITER_BUSY_POLL_EN
    logic err_d;
`else
    logic unused_dout;
    assign unused_dout = ^bus_dout;
    assign err_timeout = 1'b0;
`endif

    // Pop is taken on any clk edge; everything past IDLE advances on cen ticks only.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cs_d    = bus_cs_n;
        wr_d    = bus_wr_n;
        addr_d  = bus_addr;
        din_d   = bus_din;
`ifdef JT03_BUS_WRITER_BUSY_POLL_EN
        err_d   = err_timeout;
`endif
        if (state == IDLE) begin
            if (pop) begin
                state_d = A_SETUP;
                cnt_d   = 8'd0;
                addr_d  = 1'b0;
                din_d   = fifo_reg[rd_ptr];
            end
        end else if (cen) begin
`ifdef JT03_BUS_WRITER_BUSY_POLL_EN
            if (state == POLL) begin
                if (!bus_dout[7] || cnt == 8'd0) begin
                    state_d = IDLE;
                    cs_d    = 1'b1;
                    if (bus_dout[7]) err_d = 1'b1;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end else
`endif
            if (cnt != 8'd0) begin
                cnt_d = cnt - 8'd1;
            end else begin
                case (state)
                    A_SETUP:  begin state_d = A_STROBE; cnt_d = ticks(STROBE_TICKS); cs_d = 1'b0; wr_d = 1'b0; end
                    A_STROBE: begin state_d = A_WAIT;   cnt_d = ticks(ADDR_WAIT);    cs_d = 1'b1; wr_d = 1'b1; end
                    A_WAIT:   begin state_d = D_SETUP;  cnt_d = 8'd0; addr_d = 1'b1; din_d = data_q; end
                    D_SETUP:  begin state_d = D_STROBE; cnt_d = ticks(STROBE_TICKS); cs_d = 1'b0; wr_d = 1'b0; end
                    D_STROBE: begin
                        state_d = D_WAIT;
                        cnt_d   = fm ? ticks(FM_WAIT) : ticks(PSG_WAIT);
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
`ifdef JT03_BUS_WRITER_BUSY_POLL_EN
                        if (fm) begin
                            state_d = POLL;
                            cnt_d   = ticks(POLL_TIMEOUT);
                            addr_d  = 1'b0;
                            cs_d    = 1'b0;
                        end
`endif
                    end
                    default:  state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            reg_q    <= 8'd0;
            data_q   <= 8'd0;
            bus_cs_n <= 1'b1;
            bus_wr_n <= 1'b1;
            bus_addr <= 1'b0;
            bus_din  <= 8'd0;
            idle     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bus_cs_n <= cs_d;
            bus_wr_n <= wr_d;
            bus_addr <= addr_d;
            bus_din  <= din_d;
            idle     <= (count_d == '0) && (state_d == IDLE);
            count    <= count_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                reg_q  <= fifo_reg[rd_ptr];
                data_q <= fifo_data[rd_ptr];
            end
        end
    end

`ifdef JT03_BUS_WRITER_BUSY_POLL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_timeout <= 1'b0;
        else        err_timeout <= err_d;
    end
`endif
endmodule

// File: tb/tb_jt03_bus_writer.sv
// Self-checking bench for jt03_bus_writer: bus strobes are logged by a monitor and
// compared against timings computed from the parameter rules.
module tb_jt03_bus_writer;
    localparam int DEPTH = 4, S = 2, AWT = 17, FMW = 83, PSGW = 2, PTO = 255;

    logic       clk = 0, rst_n = 1, cen = 1, cmd_valid = 0;
    logic [7:0] cmd_reg = 0, cmd_data = 0, bus_dout = 0;
    logic       cmd_ready, bus_addr, bus_cs_n, bus_wr_n, idle, err_timeout;
    logic [7:0] bus_din;

    jt03_bus_writer #(.FIFO_DEPTH(DEPTH), .STROBE_TICKS(S), .ADDR_WAIT(AWT), .FM_WAIT(FMW),
                      .PSG_WAIT(PSGW), .POLL_TIMEOUT(PTO)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data), .bus_din(bus_din), .bus_addr(bus_addr),
        .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n), .bus_dout(bus_dout), .idle(idle),
        .err_timeout(err_timeout));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, ph = 0;
    bit cen_edge = 1, gate3 = 0;

    always @(posedge clk) begin cyc++; cen_edge = cen; end
    always @(posedge clk) begin
        #1;
        if (gate3) begin ph = (ph + 1) % 3; cen = (ph == 0); end
        else cen = 1;
    end

    typedef struct { int start; int len; logic addr; logic [7:0] din; bit stable; } strobe_t;
    strobe_t slog[$];
    strobe_t cur;
    bit      in_strobe = 0, gate_chk = 0;
    int      idle_rise = 0, gate_viol = 0;
    logic    prev_idle = 1, p_cs = 1, p_wr = 1;

    always @(negedge clk) begin
        if (!bus_cs_n && !bus_wr_n) begin
            if (!in_strobe) begin
                cur.start = cyc; cur.len = 1; cur.addr = bus_addr; cur.din = bus_din; cur.stable = 1; in_strobe = 1;
            end else begin
                cur.len++;
                if (bus_addr !== cur.addr || bus_din !== cur.din) cur.stable = 0;
            end
        end else if (in_strobe) begin
            slog.push_back(cur);
            in_strobe = 0;
        end
        if (idle && !prev_idle) idle_rise = cyc;
        if (gate_chk && !cen_edge && (bus_cs_n !== p_cs || bus_wr_n !== p_wr)) gate_viol++;
        prev_idle = idle; p_cs = bus_cs_n; p_wr = bus_wr_n;
    end

    function automatic int w(input int p); return (p < 1) ? 1 : p; endfunction
    function automatic int a_to_d(); return S + w(AWT) + 1; endfunction
    function automatic int xfer_ticks(input logic [7:0] r);
`ifdef JT03_BUS_WRITER_BUSY_POLL_EN
        return 1 + S + w(AWT) + 1 + S + ((r < 8'h10) ? w(PSGW) : 1);
`else
        return 1 + S + w(AWT) + 1 + S + ((r < 8'h10) ? w(PSGW) : w(FMW));
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] d, output int edge_n);
        cmd_reg = r; cmd_data = d; cmd_valid = 1;
        @(posedge clk); #1;
        edge_n = cyc; cmd_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle && n < budget) begin @(posedge clk); #1; n++; end
        chk("idle_reached", idle, 1'b1);
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic check_xfer(input int i, input logic [7:0] r, input logic [7:0] d, input int a_start, input int scale);
        if (slog.size() < i + 2) begin
            chk("xfer_present", slog.size(), i + 2);
            return;
        end
        if (a_start >= 0) chk("a_start", slog[i].start, a_start);
        chk("a_addr", slog[i].addr, 1'b0);
        chk("a_din", slog[i].din, r);
        chk("a_len", slog[i].len, scale * S);
        chk("d_addr", slog[i+1].addr, 1'b1);
        chk("d_din", slog[i+1].din, d);
        chk("d_len", slog[i+1].len, scale * S);
        chk("a_to_d", slog[i+1].start - slog[i].start, scale * a_to_d());
        chk("stable", slog[i].stable && slog[i+1].stable, 1'b1);
    endtask

    initial begin
        int e, p, base, a, tprev, pend, v0, e2;
        bit found;
        logic [7:0] r0, d0, rr, dd;
        logic [7:0] qr[$], qd[$];

        #1 rst_n = 0;
        #2;
        chk("rst_cs_n", bus_cs_n, 1'b1);
        chk("rst_wr_n", bus_wr_n, 1'b1);
        chk("rst_addr", bus_addr, 1'b0);
        chk("rst_din", bus_din, 8'h00);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_err", err_timeout, 1'b0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // FM write with cen held high
        base = slog.size();
        push(8'h28, 8'hF0, e); p = e + 1;
        chk("busy_after_push", idle, 1'b0);
        wait_idle(400);
        check_xfer(base, 8'h28, 8'hF0, p + 1, 1);
        chk("fm_idle_latency", idle_rise - p, xfer_ticks(8'h28));

        // reset during the data strobe with a second command queued
        push(8'h28, 8'hF0, e); push(8'h30, 8'h11, e2);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus_cs_n && !bus_wr_n && bus_addr) begin found = 1; break; end
        end
        chk("dstrobe_seen", found, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_cs_n", bus_cs_n, 1'b1);
        chk("rst_mid_wr_n", bus_wr_n, 1'b1);
        chk("rst_mid_ready", cmd_ready, 1'b1);
        chk("rst_mid_idle", idle, 1'b1);
        @(posedge clk); #3 rst_n = 1;
        @(negedge clk); @(negedge clk);
        base = slog.size();
        repeat (250) @(posedge clk);
        #1;
        chk("no_strobe_after_rst", slog.size(), base);
        chk("idle_after_flush", idle, 1'b1);

        // PSG write
        base = slog.size();
        push(8'h08, 8'h0F, e); p = e + 1;
        wait_idle(400);
        check_xfer(base, 8'h08, 8'h0F, p + 1, 1);
        chk("psg_idle_latency", idle_rise - p, xfer_ticks(8'h08));

        // FIFO full: FSM busy, five back-to-back pushes
        base = slog.size();
        r0 = 8'($urandom); d0 = 8'($urandom);
        push(r0, d0, e); p = e + 1;
        repeat (2) @(posedge clk);
        #1;
        pend = 0;
        for (int k = 0; k < 5; k++) begin
            rr = 8'($urandom_range(0, 255)); dd = 8'($urandom);
            chk("ready_before_push", cmd_ready, pend < DEPTH);
            if (pend < DEPTH) begin qr.push_back(rr); qd.push_back(dd); pend++; end
            push(rr, dd, e);
        end
        chk("ready_when_full", cmd_ready, 1'b0);
        wait_idle(3000);
        chk("xfer_count", slog.size() - base, 2 * (1 + qr.size()));
        check_xfer(base, r0, d0, p + 1, 1);
        a = p + 1; tprev = xfer_ticks(r0);
        foreach (qr[k]) begin
            a = a + tprev + 1;
            check_xfer(base + 2 * (k + 1), qr[k], qd[k], a, 1);
            tprev = xfer_ticks(qr[k]);
        end

        // cen one tick in three
        gate3 = 1;
        repeat (3) @(posedge clk);
        #1;
        v0 = gate_viol; gate_chk = 1; base = slog.size();
        rr = 8'($urandom); dd = 8'($urandom);
        push(rr, dd, e);
        wait_idle(1500);
        gate_chk = 0; gate3 = 0;
        check_xfer(base, rr, dd, -1, 3);
        chk("cen0_steady", gate_viol - v0, 0);

`ifdef JT03_BUS_WRITER_BUSY_POLL_EN
        // busy for ten samples, clear on the eleventh
        bus_dout = 8'h80;
        push(8'h40, 8'h55, e);
        found = 0; p = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus_cs_n && bus_wr_n) begin found = 1; p = cyc; break; end
        end
        chk("poll_seen", found, 1'b1);
        chk("poll_addr", bus_addr, 1'b0);
        repeat (10) @(posedge clk);
        #1 bus_dout = 8'h00;
        wait_idle(100);
        chk("poll_exit", idle_rise - p, 11);
        chk("poll_no_err", err_timeout, 1'b0);

        // busy stuck: timeout, then the queued PSG write still runs
        base = slog.size();
        bus_dout = 8'h80;
        push(8'h40, 8'h66, e); push(8'h08, 8'h0F, e2);
        found = 0; p = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus_cs_n && bus_wr_n) begin found = 1; p = cyc; break; end
        end
        chk("poll2_seen", found, 1'b1);
        repeat (PTO - 1) @(posedge clk);
        #1 chk("err_before_timeout", err_timeout, 1'b0);
        @(posedge clk); #1;
        chk("err_at_timeout", err_timeout, 1'b1);
        bus_dout = 8'h00;
        wait_idle(400);
        chk("xfers_after_timeout", slog.size() - base, 4);
        check_xfer(base + 2, 8'h08, 8'h0F, p + PTO + 2, 1);
        chk("err_sticky", err_timeout, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
